// File: rtl/pid_core.sv
// Fixed-point PID stage: P, I and D terms share one multiply-accumulate, sequenced by an FSM.
// Optional build macro PID_ANTIWINDUP_EN freezes the integrator while the output is clamped in the same direction.
//
// state   | meaning
// IDLE    | ready, waiting for a sample
// ERR     | form error e and derivative d
// MUL_P   | acc = kp*e
// MUL_I   | update integrator, acc += ki*integ
// MUL_D   | acc += kd*d, clamp and publish ctrl_out with strobe
// OUT     | strobe cycle, return to IDLE
module pid_core #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int INT_W     = 32,
  parameter int OUT_W     = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic signed [GAIN_W-1:0] kd,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] meas,
  input  logic                     meas_valid,
  output logic                     ready,
  input  logic                     clear,
  output logic signed [OUT_W-1:0]  ctrl_out,
  output logic                     out_valid,
  output logic                     sat
);

  localparam int E_W   = DATA_W + 1;
  localparam int D_W   = DATA_W + 2;
  localparam int ACC_W = GAIN_W + INT_W + 2;

  localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN   = ~Y_MAX;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = ~INT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] sp_q, meas_q;
  logic signed [GAIN_W-1:0] kp_q, ki_q, kd_q;
  logic signed [E_W-1:0]    e, e_prev;
  logic signed [D_W-1:0]    d;
  logic signed [INT_W-1:0]  integ;
  logic signed [ACC_W-1:0]  acc;
`ifdef PID_ANTIWINDUP_EN
  logic                     sat_pos;
`endif

  logic signed [E_W-1:0]    e_calc;
  logic signed [INT_W:0]    integ_sum;
  logic signed [INT_W-1:0]  integ_upd, integ_new;
  logic signed [ACC_W-1:0]  prod_p, prod_i, acc_fin, y;
  logic signed [OUT_W-1:0]  ctrl_nx;
  logic                     sat_nx, sat_hi_nx;

  always_comb begin
    e_calc    = E_W'(sp_q) - E_W'(meas_q);
    integ_sum = (INT_W+1)'(integ) + (INT_W+1)'(e);
    // one extra bit exposes overflow; clamp toward the sign of the true sum
    if (integ_sum[INT_W] != integ_sum[INT_W-1])
      integ_upd = integ_sum[INT_W] ? INT_MIN : INT_MAX;
    else
      integ_upd = integ_sum[INT_W-1:0];
`ifdef PID_ANTIWINDUP_EN
    if (sat && (e != '0) && (e[E_W-1] == ~sat_pos))
      integ_new = integ;
    else
      integ_new = integ_upd;
`else
    integ_new = integ_upd;
`endif
    prod_p  = ACC_W'(kp_q) * ACC_W'(e);
    prod_i  = ACC_W'(ki_q) * ACC_W'(integ_new);
    acc_fin = acc + ACC_W'(kd_q) * ACC_W'(d);
    y       = acc_fin >>> FRAC_BITS;
    sat_hi_nx = 1'b0;
    if (y > Y_MAX) begin
      ctrl_nx   = OUT_MAX;
      sat_nx    = 1'b1;
      sat_hi_nx = 1'b1;
    end else if (y < Y_MIN) begin
      ctrl_nx = OUT_MIN;
      sat_nx  = 1'b1;
    end else begin
      ctrl_nx = y[OUT_W-1:0];
      sat_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      ctrl_out  <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e         <= '0;
      e_prev    <= '0;
      d         <= '0;
      integ     <= '0;
      acc       <= '0;
`ifdef PID_ANTIWINDUP_EN
      sat_pos   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        integ  <= '0;
        e_prev <= '0;
        state  <= S_IDLE;
        ready  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (meas_valid) begin
            sp_q   <= setpoint;
            meas_q <= meas;
            kp_q   <= kp;
            ki_q   <= ki;
            kd_q   <= kd;
            ready  <= 1'b0;
            state  <= S_ERR;
          end
          S_ERR: begin
            e     <= e_calc;
            d     <= D_W'(e_calc) - D_W'(e_prev);
            state <= S_MUL_P;
          end
          S_MUL_P: begin
            acc   <= prod_p;
            state <= S_MUL_I;
          end
          S_MUL_I: begin
            integ <= integ_new;
            acc   <= acc + prod_i;
            state <= S_MUL_D;
          end
          // publish here so ctrl_out is valid during the strobe cycle
          S_MUL_D: begin
            acc       <= acc_fin;
            ctrl_out  <= ctrl_nx;
            sat       <= sat_nx;
`ifdef PID_ANTIWINDUP_EN
            sat_pos   <= sat_hi_nx;
`endif
            e_prev    <= e;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
          S_OUT: begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
          default: begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// Scoreboard bench for pid_core: a reference model pushes expected outputs, a monitor pops them on each strobe.
module tb_pid_core;

  logic               clk_in = 1'b0;
  logic               reset;
  logic signed [15:0] kp, ki, kd, setpoint, meas;
  logic               meas_valid, clear, ready, out_valid, sat;
  logic signed [15:0] ctrl_out;

  pid_core dut (
    .clk_in(clk_in), .reset(reset), .kp(kp), .ki(ki), .kd(kd),
    .setpoint(setpoint), .meas(meas), .meas_valid(meas_valid), .ready(ready),
    .clear(clear), .ctrl_out(ctrl_out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { longint ctrl; bit sat; } exp_t;
  exp_t sb_q[$];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint integ_m = 0, e_prev_m = 0, last_ctrl_m = 0;
  bit     sat_m = 0, satpos_m = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model, computed on the gains present when the sample is driven
  task automatic model_push(input longint sp, input longint ms);
    longint e, d, upd, acc, y;
    exp_t   x;
    e   = sp - ms;
    d   = e - e_prev_m;
    upd = integ_m + e;
    if (upd > 64'sd2147483647) upd = 64'sd2147483647;
    if (upd < -64'sd2147483648) upd = -64'sd2147483648;
`ifdef PID_ANTIWINDUP_EN
    if (sat_m && ((e > 0 && satpos_m) || (e < 0 && !satpos_m))) upd = integ_m;
`endif
    integ_m = upd;
    acc = longint'(kp) * e + longint'(ki) * integ_m + longint'(kd) * d;
    y   = acc >>> 8;
    x.sat = 1'b1;
    if (y > 32767) begin
      x.ctrl = 32767; satpos_m = 1'b1;
    end else if (y < -32768) begin
      x.ctrl = -32768; satpos_m = 1'b0;
    end else begin
      x.ctrl = y; x.sat = 1'b0;
    end
    sat_m       = x.sat;
    last_ctrl_m = x.ctrl;
    e_prev_m    = e;
    sb_q.push_back(x);
  endtask

  always @(negedge clk_in) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("ctrl_out", $signed(ctrl_out), x.ctrl);
        check("sat", sat, x.sat);
      end
    end
  end

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk_in);
    clear = 1'b0;
    integ_m  = 0;
    e_prev_m = 0;
  endtask

  // mode 0 normal, 1 busy meas_valid + kp change, 2 reset in MUL_I, 3 clear in MUL_P
  task automatic send(input int sp, input int ms, input int mode);
    int waitc = 0, first = 0, strobes = 0;
    logic signed [15:0] kp_save;
    while (!ready && waitc < 20) begin
      @(negedge clk_in);
      waitc++;
    end
    check("ready_before_send", ready, 1);
    setpoint   = 16'(sp);
    meas       = 16'(ms);
    meas_valid = 1'b1;
    kp_save    = kp;
    if (mode <= 1) model_push(sp, ms);
    @(negedge clk_in);
    meas_valid = 1'b0;
    check("ready_busy", ready, 0);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk_in);
      if (mode == 1 && k == 2) begin
        meas_valid = 1'b1;
        setpoint   = 16'(sp + 500);
        kp         = 16'sh0000;
        check("ready_in_mul_p", ready, 0);
      end
      if (mode == 1 && k == 3) begin
        meas_valid = 1'b0;
        setpoint   = 16'(sp);
      end
      if (mode == 3 && k == 2) clear = 1'b1;
      if (mode == 3 && k == 3) begin
        clear = 1'b0;
        integ_m = 0;
        e_prev_m = 0;
        check("clear_abort_ready", ready, 1);
        check("clear_ctrl_hold", $signed(ctrl_out), last_ctrl_m);
        check("clear_sat_hold", sat, sat_m);
      end
      if (mode == 2 && k == 3) begin
        reset = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_ctrl_out", $signed(ctrl_out), 0);
        check("rst_sat", sat, 0);
        check("rst_out_valid", out_valid, 0);
        #1 reset = 1'b0;
        integ_m = 0; e_prev_m = 0; sat_m = 0; satpos_m = 0; last_ctrl_m = 0;
      end
      if (out_valid) begin
        strobes++;
        if (first == 0) first = k;
      end
    end
    kp = kp_save;
    if (mode <= 1) begin
      check("strobe_latency", first, 5);
      check("strobe_width", strobes, 1);
    end else begin
      check("aborted_no_strobe", strobes, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; meas_valid = 1'b0;
    kp = '0; ki = '0; kd = '0; setpoint = '0; meas = '0;
    repeat (2) @(negedge clk_in);
    check("reset_ready", ready, 1);
    check("reset_ctrl_out", $signed(ctrl_out), 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_sat", sat, 0);
    reset = 1'b0;
    @(negedge clk_in);

    kp = 16'sh0100;
    send(100, 0, 0);

    do_clear();
    kp = '0; ki = 16'sh0080;
    send(10, 0, 0);
    send(10, 0, 0);

    do_clear();
    ki = '0; kd = 16'sh0100;
    send(100, 0, 0);
    send(100, 0, 0);
    do_clear();
    send(50, 0, 0);

    do_clear();
    kd = '0; kp = 16'sh7FFF;
    send(1000, 0, 0);
    send(0, 1000, 0);

    do_clear();
    kp = 16'sh0100;
    send(200, 50, 1);
    send(300, 0, 3);

    kp = '0; ki = 16'sh0100;
    send(40, 0, 0);
    send(40, 0, 2);
    @(negedge clk_in);
    send(10, 0, 0);

    do_clear();
    kp = 16'sh7FFF;
    send(1000, 0, 0);
    send(1000, 0, 0);
    send(1000, 0, 0);
    kp = '0;
    send(0, 0, 0);

    repeat (4) @(negedge clk_in);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_core.md
Name: pid_core

Overview:
- Fixed-point PID compute stage, directly downstream of the gain memory.
- The memory block drives the gain inputs (kp, ki, kd); this block consumes them.
- Takes setpoint/measurement samples over a valid/ready handshake.
- Sequences P, I and D terms through one shared multiply-accumulate using an FSM, then emits a saturated control word with a one-cycle valid strobe.

Parameters:
DATA_W, 16, width of signed setpoint/measurement
GAIN_W, 16, width of signed gains, Q(GAIN_W-FRAC_BITS).FRAC_BITS
FRAC_BITS, 8, fractional bits of gains; accumulator shifted right by this before output
INT_W, 32, width of signed saturating integrator
OUT_W, 16, width of signed control output

Ports:
clk_in  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
kp  input  GAIN_W  proportional gain (signed), from memory block
ki  input  GAIN_W  integral gain (signed)
kd  input  GAIN_W  derivative gain (signed)
setpoint  input  DATA_W  signed target value
meas  input  DATA_W  signed measured value
meas_valid  input  1  sample present
ready  output  1  block idle, sample accepted when meas_valid&ready
clear  input  1  synchronous pulse: zero integrator and previous error
ctrl_out  output  OUT_W  signed control output
out_valid  output  1  one-cycle strobe, ctrl_out updated
sat  output  1  last ctrl_out was clamped

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous and active-high.
- Reset: state IDLE, ready=1, ctrl_out=0, out_valid=0, sat=0, integrator=0, e_prev=0, accumulator=0.
- Accept: in IDLE with meas_valid=1, register setpoint, meas, kp, ki and kd (gain snapshot; memory writes mid-calculation have no effect). Go to ERR; ready=0.
- FSM, one state per cycle:
  - IDLE -> ERR.
  - ERR: e = setpoint - meas (DATA_W+1 bits, sign-extended); d = e - e_prev (DATA_W+2 bits) -> MUL_P.
  - MUL_P: acc = kp*e -> MUL_I.
  - MUL_I: integ = sat_INT_W(integ + e); acc += ki*integ(new) -> MUL_D.
  - MUL_D: acc += kd*d -> OUT.
  - OUT: y = acc >>> FRAC_BITS (arithmetic); ctrl_out = clamp(y, -2^(OUT_W-1), 2^(OUT_W-1)-1); sat = clamped; e_prev = e; out_valid=1 -> IDLE.
- Accumulator width GAIN_W+INT_W+2, signed; no overflow possible.
- Latency: out_valid is high during the 5th cycle after the accepting edge. Throughput: one sample per 6 cycles. ready is high only in IDLE. meas_valid while busy is ignored (not queued).
- out_valid high exactly one cycle. ctrl_out and sat hold between strobes.
- Integrator saturates at ±(2^(INT_W-1)-1 / -2^(INT_W-1)); never wraps.
- clear:
  - In IDLE: zero integ and e_prev.
  - Mid-calculation: also abort to IDLE, no out_valid; ctrl_out and sat hold.
  - clear and meas_valid in the same IDLE cycle: clear wins, sample not accepted.
- Asynchronous reset mid-calculation: immediate return to reset values; no strobe.

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- Defined: in MUL_I, the integrator update is skipped (integ holds) when the previous output had sat=1 and sign(e) equals the sign of the saturation direction. The held integ value is used in the ki product.
- Undefined: the integrator always updates, with INT_W saturation only.

Test Plan:
- kp=0x0100, ki=0, kd=0, setpoint=100, meas=0 -> ctrl_out=100, sat=0; out_valid high on the 5th cycle after accept for exactly 1 cycle.
- kp=0, ki=0x0080 (0.5), kd=0, setpoint=10, meas=0, two samples -> ctrl_out=5 then 10.
- kp=0, ki=0, kd=0x0100; samples e=100 then e=100 -> ctrl_out=100 then 0. Then clear, then e=50 -> ctrl_out=50.
- kp=0x7FFF, setpoint=1000, meas=0 -> ctrl_out=32767, sat=1. Negated (meas=1000, setpoint=0) -> ctrl_out=-32768, sat=1.
- Assert meas_valid during MUL_P -> ignored, ready=0. Change kp mid-calculation -> result uses the snapshot.
- Assert reset in MUL_I -> ready=1, ctrl_out=0, integ=0 immediately. With PID_ANTIWINDUP_EN, saturated case: integ holds across 3 saturated samples.
